// File: rtl/word_masked_sram.sv
// word_masked_sram: register-file memory with per-word synchronous write enables and asynchronous read.
module word_masked_sram #(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 4,
    parameter int WORD_SIZE    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LOG_NUM_ROWS-1:0] readAddr,
    input  logic [LOG_NUM_ROWS-1:0] writeAddr,
    input  logic [WIDTH-1:0]        writeData,
    input  logic [WIDTH/WORD_SIZE-1:0] writeEnable,
    output logic [WIDTH-1:0]        readData
);
    localparam int NUM_ROWS  = 2 ** LOG_NUM_ROWS;
    localparam int NUM_WORDS = WIDTH / WORD_SIZE;

    if (WIDTH % WORD_SIZE != 0) begin : g_width_check
        $error("WIDTH must be an integer multiple of WORD_SIZE");
    end

    logic [WIDTH-1:0] r_mem [NUM_ROWS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) r_mem[r] <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++)
                if (writeEnable[i]) r_mem[writeAddr][i*WORD_SIZE +: WORD_SIZE] <= writeData[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign readData = r_mem[readAddr];
endmodule

// File: tb/tb_word_masked_sram.sv
// tb_word_masked_sram: directed, table-driven and randomized checks against an array reference model.
module tb_word_masked_sram;
    logic         clk = 0;
    logic         reset = 0;
    logic [3:0]   readAddr = 0, writeAddr = 0;
    logic [511:0] writeData = 0;
    logic [15:0]  writeEnable = 0;
    logic [511:0] readData;

    logic       n_reset = 0;
    logic [3:0] n_ra = 0, n_wa = 0;
    logic       n_wd = 0, n_we = 0;
    logic       n_rd;

    int errors = 0;
    int checks = 0;
    logic [511:0] model [16];

    always #5 clk = ~clk;

    word_masked_sram u_dut (
        .clk(clk), .reset(reset), .readAddr(readAddr), .writeAddr(writeAddr),
        .writeData(writeData), .writeEnable(writeEnable), .readData(readData)
    );

    word_masked_sram #(.WIDTH(1), .LOG_NUM_ROWS(4), .WORD_SIZE(1)) u_narrow (
        .clk(clk), .reset(n_reset), .readAddr(n_ra), .writeAddr(n_wa),
        .writeData(n_wd), .writeEnable(n_we), .readData(n_rd)
    );

    typedef struct {
        bit       rst;
        bit       en;
        bit       d;
        bit [3:0] wa;
        bit [3:0] ra;
        bit       exp;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference update: each data bit is taken when its word's enable is set.
    task automatic model_write(input logic rst, input logic [3:0] wa, input logic [15:0] en, input logic [511:0] d);
        logic [511:0] m;
        if (rst) begin
            for (int r = 0; r < 16; r++) model[r] = '0;
        end else begin
            for (int b = 0; b < 512; b++) m[b] = en[b/32];
            model[wa] = (model[wa] & ~m) | (d & m);
        end
    endtask

    task automatic wr(input logic rst, input logic [3:0] wa, input logic [15:0] en, input logic [511:0] d, input bit pre);
        @(negedge clk);
        reset = rst; writeAddr = wa; writeEnable = en; writeData = d;
        #1;
        if (pre) chk("pre_edge_old", readData, model[readAddr]);
        @(posedge clk);
        #1;
        model_write(rst, wa, en, d);
        reset = 0; writeEnable = '0;
    endtask

    task automatic rd(input logic [3:0] a, input string nm);
        readAddr = a;
        #1;
        chk(nm, readData, model[a]);
    endtask

    task automatic rand_data(output logic [511:0] d);
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    endtask

    initial begin
        vec_t vt [10];
        logic [511:0] ones, p, exp, d;
        logic [15:0] en;
        logic [3:0] wa;

        vt[0] = '{1, 0, 0, 0, 9, 0};
        vt[1] = '{0, 1, 1, 9, 9, 1};
        vt[2] = '{0, 0, 0, 9, 9, 1};
        vt[3] = '{0, 1, 0, 9, 9, 0};
        vt[4] = '{0, 0, 1, 9, 9, 0};
        vt[5] = '{0, 1, 1, 9, 9, 1};
        vt[6] = '{0, 1, 1, 8, 9, 1};
        vt[7] = '{0, 1, 0, 8, 8, 0};
        vt[8] = '{1, 1, 1, 9, 9, 0};
        vt[9] = '{0, 0, 0, 0, 8, 0};

        ones = '1;
        wr(1, 0, 16'h0000, '0, 0);
        for (int r = 0; r < 16; r++) begin
            readAddr = r[3:0];
            #1;
            chk("reset_init", readData, '0);
        end

        wr(0, 3, 16'hFFFF, ones, 0);
        rd(3, "row3_ones");
        chk("row3_ones_const", readData, ones);
        wr(1, 0, 16'h0000, '0, 0);
        for (int r = 0; r < 16; r++) begin
            readAddr = r[3:0];
            #1;
            chk("reset_clears", readData, '0);
        end

        d = {16{32'h11111111}};
        d[64 +: 32] = 32'hDEADBEEF;
        wr(0, 5, 16'h0004, d, 0);
        exp = '0;
        exp[64 +: 32] = 32'hDEADBEEF;
        readAddr = 5;
        #1;
        chk("masked_word2", readData, exp);

        rand_data(p);
        readAddr = 7;
        wr(0, 7, 16'hFFFF, p, 1);
        chk("post_edge_new", readData, p);

        wr(0, 0, 16'hFFFF, {16{32'hA5A5A5A5}}, 0);
        wr(0, 15, 16'hFFFF, {16{32'h5A5A5A5A}}, 0);
        readAddr = 0;
        #1;
        chk("row0_pattern", readData, {16{32'hA5A5A5A5}});
        readAddr = 15;
        #1;
        chk("row15_pattern", readData, {16{32'h5A5A5A5A}});
        for (int r = 1; r < 15; r++) rd(r[3:0], "rows_unchanged");

        wr(0, 2, 16'hFFFF, ones, 0);
        wr(1, 2, 16'hFFFF, ones, 0);
        readAddr = 2;
        #1;
        chk("reset_beats_write", readData, '0);

        for (int k = 0; k < 300; k++) begin
            rand_data(d);
            en = $urandom;
            if (k % 7 == 0) en = 16'h0000;
            if (k % 11 == 0) en = 16'hFFFF;
            wa = $urandom;
            readAddr = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom);
            wr(($urandom_range(0, 49) == 0), wa, en, d, 1);
            rd(wa, "rand_written_row");
            rd(4'($urandom), "rand_any_row");
        end

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_reset = vt[k].rst; n_we = vt[k].en; n_wd = vt[k].d; n_wa = vt[k].wa;
            @(posedge clk);
            #1;
            n_reset = 0; n_we = 0;
            n_ra = vt[k].ra;
            #1;
            chk($sformatf("narrow_vec%0d", k), {511'b0, n_rd}, {511'b0, vt[k].exp});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
